// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the counter/timer family: FSM state encoding
// and a small helper used to derive the busy flag.
package counter_pkg;

  // State encoding kept as plain 2-bit constants so older blocks that
  // compare against raw codes keep working; the unused code 2'd3 falls
  // back to IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // A timer is busy while it owns a count in progress (running or paused).
  function automatic logic state_is_busy(input logic [1:0] state);
    return (state == ST_RUN) || (state == ST_HOLD);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer. The master side
// (software or a parent FSM) programs and starts the timer; the slave
// side is the timer itself.
interface countdown_timer_if #(
  parameter int N = 8
);
  import counter_pkg::*;

  logic         load_en;
  logic [N-1:0] data_in;
  logic         start;
  logic         hold;
  logic         auto_reload;
  logic [N-1:0] count_out;
  logic         busy;
  logic         tc_pulse;

  modport master (
    output load_en, data_in, start, hold, auto_reload,
    input  count_out, busy, tc_pulse
  );

  modport slave (
    input  load_en, data_in, start, hold, auto_reload,
    output count_out, busy, tc_pulse
  );

endinterface

// File: rtl/countdown_timer.sv
// Loadable N-bit down-counter with pause and optional periodic reload.
// Produces a registered one-cycle terminal-count strobe when a run
// expires. The count never wraps: it only decrements while nonzero.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ZERO = '0;

  logic [1:0]   state_reg,  state_next;
  logic [N-1:0] count_reg,  count_next;
  logic [N-1:0] reload_reg, reload_next;
  logic         tc_reg,     tc_next;

  // Next-state logic; priority is load_en > start > hold > count.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;

    if (bus.load_en) begin
      // A load aborts any run silently and parks the timer in IDLE.
      reload_next = bus.data_in;
      count_next  = bus.data_in;
      state_next  = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            if (count_reg != ZERO) begin
              // Arm only; the first decrement happens on the next edge.
              state_next = ST_RUN;
            end else begin
              // Nothing to count: expire immediately without going busy.
              tc_next = 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (bus.hold) begin
            state_next = ST_HOLD;
          end else if (count_reg == ONE) begin
            // Terminal edge; auto_reload is only looked at here.
            tc_next = 1'b1;
            if (bus.auto_reload && (reload_reg != ZERO)) begin
              count_next = reload_reg;
            end else begin
              // One-shot, or a zero period that must not spin forever.
              count_next = ZERO;
              state_next = ST_IDLE;
            end
          end else if (count_reg != ZERO) begin
            count_next = count_reg - ONE;
          end else begin
            // Defensive: a zero count has nothing left to run.
            state_next = ST_IDLE;
          end
        end

        ST_HOLD: begin
          // Count frozen; release resumes decrementing on the next edge.
          if (!bus.hold) begin
            state_next = ST_RUN;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Single register bank for state, count, reload value and strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= ZERO;
      reload_reg <= ZERO;
      tc_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
    end
  end

  // Outputs: count and strobe straight from registers, busy from state.
  always_comb begin
    bus.count_out = count_reg;
    bus.tc_pulse  = tc_reg;
    bus.busy      = state_is_busy(state_reg);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: an 8-bit instance exercises
// the control scenarios cycle by cycle through a scoreboard of expected
// (count, busy, tc) triples; a 16-bit instance runs a full-width count.
module tb_countdown_timer;

  typedef struct packed {
    logic [7:0] cnt;
    logic       busy;
    logic       tc;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors;
  int   errors;
  exp_t sb[$];
  int   sb_wide[$];

  countdown_timer_if #(.N(8))  b8 ();
  countdown_timer_if #(.N(16)) b16 ();

  countdown_timer #(.N(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  countdown_timer #(.N(16)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset held two cycles while load_en tries to load 8'h55.
  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    b8.load_en  = 1'b1; b8.data_in  = 8'h55;
    b16.load_en = 1'b1; b16.data_in = 16'h5555;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{8'h00, 1'b0, 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({b8.count_out, b8.busy, b8.tc_pulse} !== {e.cnt, e.busy, e.tc}) begin
        errors++;
        $display("FAIL reset[%0d] got cnt=%0h busy=%b tc=%b want cnt=%0h busy=%b tc=%b",
                 i, b8.count_out, b8.busy, b8.tc_pulse, e.cnt, e.busy, e.tc);
      end
      vectors++;
      if ({b16.count_out, b16.busy, b16.tc_pulse} !== {16'h0000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset16[%0d] got cnt=%0h busy=%b tc=%b want cnt=0 busy=0 tc=0",
                 i, b16.count_out, b16.busy, b16.tc_pulse);
      end
    end
    reset = 1'b0;
    b8.load_en  = 1'b0;
    b16.load_en = 1'b0;
  endtask

  // One-shot from 5; auto_reload toggled mid-run but 0 at the terminal edge.
  task automatic test_oneshot();
    exp_t e;
    logic [7:0] ec [8] = '{8'd5, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    logic       eb [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       et [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      b8.load_en = (i == 0); b8.data_in = 8'd5; b8.start = (i == 1);
      b8.auto_reload = (i >= 2 && i <= 4);
      sb.push_back('{ec[i], eb[i], et[i]});
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({b8.count_out, b8.busy, b8.tc_pulse} !== {e.cnt, e.busy, e.tc}) begin
        errors++;
        $display("FAIL oneshot[%0d] got cnt=%0h busy=%b tc=%b want cnt=%0h busy=%b tc=%b",
                 i, b8.count_out, b8.busy, b8.tc_pulse, e.cnt, e.busy, e.tc);
      end
    end
    b8.auto_reload = 1'b0; b8.start = 1'b0; b8.load_en = 1'b0;
  endtask

  // Periodic mode with period 3, then drop to one-shot before a terminal edge.
  task automatic test_auto_reload();
    exp_t e;
    logic [7:0] ec [12] = '{8'd3, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    logic       eb [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       et [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      b8.load_en = (i == 0); b8.data_in = 8'd3; b8.start = (i == 1);
      b8.auto_reload = (i < 9);
      sb.push_back('{ec[i], eb[i], et[i]});
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({b8.count_out, b8.busy, b8.tc_pulse} !== {e.cnt, e.busy, e.tc}) begin
        errors++;
        $display("FAIL auto[%0d] got cnt=%0h busy=%b tc=%b want cnt=%0h busy=%b tc=%b",
                 i, b8.count_out, b8.busy, b8.tc_pulse, e.cnt, e.busy, e.tc);
      end
    end
    b8.auto_reload = 1'b0; b8.start = 1'b0; b8.load_en = 1'b0;
  endtask

  // Hold for three edges at count 4; start pulses in HOLD/RUN are ignored.
  task automatic test_hold();
    exp_t e;
    logic [7:0] ec [13] = '{8'd6, 8'd6, 8'd5, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    logic       eb [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      b8.load_en = (i == 0); b8.data_in = 8'd6;
      b8.start = (i == 1) || (i == 5) || (i == 8);
      b8.hold  = (i >= 4 && i <= 6);
      sb.push_back('{ec[i], eb[i], (i == 11)});
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({b8.count_out, b8.busy, b8.tc_pulse} !== {e.cnt, e.busy, e.tc}) begin
        errors++;
        $display("FAIL hold[%0d] got cnt=%0h busy=%b tc=%b want cnt=%0h busy=%b tc=%b",
                 i, b8.count_out, b8.busy, b8.tc_pulse, e.cnt, e.busy, e.tc);
      end
    end
    b8.hold = 1'b0; b8.start = 1'b0; b8.load_en = 1'b0;
  endtask

  // Abort at count 2 by loading 8'h20, then a full 32-cycle run.
  task automatic test_abort_reload();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      b8.load_en = (i == 0) || (i == 4);
      b8.data_in = (i == 0) ? 8'd4 : 8'h20;
      b8.start   = (i == 1) || (i == 6);
      if (i == 0)      e = '{8'd4, 1'b0, 1'b0};
      else if (i == 1) e = '{8'd4, 1'b1, 1'b0};
      else if (i < 4)  e = '{8'(5 - i), 1'b1, 1'b0};
      else if (i < 6)  e = '{8'h20, 1'b0, 1'b0};
      else if (i == 6) e = '{8'h20, 1'b1, 1'b0};
      else if (i < 38) e = '{8'(8'h20 - (i - 6)), 1'b1, 1'b0};
      else if (i == 38) e = '{8'h00, 1'b0, 1'b1};
      else             e = '{8'h00, 1'b0, 1'b0};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({b8.count_out, b8.busy, b8.tc_pulse} !== {e.cnt, e.busy, e.tc}) begin
        errors++;
        $display("FAIL abort[%0d] got cnt=%0h busy=%b tc=%b want cnt=%0h busy=%b tc=%b",
                 i, b8.count_out, b8.busy, b8.tc_pulse, e.cnt, e.busy, e.tc);
      end
    end
    b8.start = 1'b0; b8.load_en = 1'b0;
  endtask

  // Reset mid-run wins over simultaneous load_en and start; then start at zero.
  task automatic test_reset_and_zero_start();
    exp_t e;
    logic [7:0] ec [7] = '{8'd9, 8'd9, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
    logic       eb [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       et [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      reset = (i == 3);
      b8.load_en = (i == 0) || (i == 3);
      b8.data_in = (i == 0) ? 8'd9 : 8'h77;
      b8.start   = (i == 1) || (i == 3) || (i == 5);
      sb.push_back('{ec[i], eb[i], et[i]});
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({b8.count_out, b8.busy, b8.tc_pulse} !== {e.cnt, e.busy, e.tc}) begin
        errors++;
        $display("FAIL zero_start[%0d] got cnt=%0h busy=%b tc=%b want cnt=%0h busy=%b tc=%b",
                 i, b8.count_out, b8.busy, b8.tc_pulse, e.cnt, e.busy, e.tc);
      end
    end
    reset = 1'b0; b8.start = 1'b0; b8.load_en = 1'b0;
  endtask

  // 16-bit instance: 16'hFFFF must expire after exactly 65535 edges, no wrap.
  task automatic test_wide16();
    int n;
    int want;
    b16.load_en = 1'b1; b16.data_in = 16'hFFFF;
    @(posedge clk); #1;
    vectors++;
    if ({b16.count_out, b16.busy} !== {16'hFFFF, 1'b0}) begin
      errors++;
      $display("FAIL wide_load got cnt=%0h busy=%b want cnt=ffff busy=0", b16.count_out, b16.busy);
    end
    b16.load_en = 1'b0; b16.start = 1'b1;
    sb_wide.push_back(65535);
    @(posedge clk); #1;
    b16.start = 1'b0;
    n = 0;
    while (n < 70000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1000) begin
        vectors++;
        if (b16.count_out !== 16'(16'hFFFF - 1000)) begin
          errors++;
          $display("FAIL wide_mid got cnt=%0h want cnt=%0h", b16.count_out, 16'(16'hFFFF - 1000));
        end
      end
      if (b16.tc_pulse === 1'b1) break;
    end
    want = sb_wide.pop_front(); vectors++;
    if (n != want) begin
      errors++;
      $display("FAIL wide_latency got %0d cycles want %0d", n, want);
    end
    vectors++;
    if ({b16.count_out, b16.busy} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL wide_end got cnt=%0h busy=%b want cnt=0 busy=0", b16.count_out, b16.busy);
    end
    @(posedge clk); #1;
    vectors++;
    if ({b16.count_out, b16.busy, b16.tc_pulse} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wide_nowrap got cnt=%0h busy=%b tc=%b want cnt=0 busy=0 tc=0",
               b16.count_out, b16.busy, b16.tc_pulse);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    b8.load_en  = 1'b0; b8.data_in  = '0; b8.start  = 1'b0; b8.hold  = 1'b0; b8.auto_reload  = 1'b0;
    b16.load_en = 1'b0; b16.data_in = '0; b16.start = 1'b0; b16.hold = 1'b0; b16.auto_reload = 1'b0;

    test_reset();
    test_oneshot();
    test_auto_reload();
    test_hold();
    test_abort_reload();
    test_reset_and_zero_start();
    test_wide16();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
